lif_neuron_array: RTL and testbench

- Parametrised multi-channel leaky integrate-and-fire neuron array. Successor to the single-neuron board-level LIF design.
- N_CH independent neurons share one time-step prescaler, a runtime threshold, a runtime leak shift and a reset mode.
- Each neuron integrates a multi-bit input current and emits one-cycle spike pulses. A refractory period follows every spike.
- Per-channel saturating spike counters and a selected-channel membrane readout drive the display/debug path at top level.

---
 rtl/lif_pkg.sv | 12 +
 rtl/lif_neuron.sv | 47 ++++
 rtl/lif_neuron_array.sv | 72 +++++++
 tb/tb_lif_neuron_array.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/lif_pkg.sv
// lif_pkg: shared widths, reset-mode encodings and arithmetic helpers for the LIF array
package lif_pkg;
   localparam int   LS_W     = 4;
   localparam logic RST_ZERO = 1'b0;
   localparam logic RST_SUB  = 1'b1;
   // unsigned add that clips at max instead of wrapping
   function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b, input logic [31:0] max);
      logic [32:0] s;
      s = {1'b0, a} + {1'b0, b};
      return (s > {1'b0, max}) ? max : s[31:0];
   endfunction
endpackage

// File: rtl/lif_neuron.sv
// lif_neuron: one leaky integrate-and-fire channel, advanced only on the shared update strobe
module lif_neuron
   import lif_pkg::*;
#(
   parameter int W            = 8,
   parameter int IN_W         = 8,
   parameter int REFRAC_TICKS = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            upd,
   input  logic [IN_W-1:0] cur,
   input  logic [W-1:0]    threshold,
   input  logic [LS_W-1:0] leak_shift,
   input  logic            reset_mode,
   output logic            spike,
   output logic [W-1:0]    vmem
);
   localparam int RC_W = REFRAC_TICKS > 0 ? $clog2(REFRAC_TICKS + 1) : 1;
   logic [W-1:0]    v_q, v_d, leaked, vi;
   logic [RC_W-1:0] rc_q, rc_d;
   logic            spike_q, spike_d, refrac, fire;
   // leak, integrate with saturation, fire decision and post-fire membrane value
   always_comb begin
      leaked  = v_q - (v_q >> leak_shift);
      vi      = W'(sat_add(32'(leaked), 32'(cur), 32'(2**W - 1)));
      refrac  = rc_q != '0;
      fire    = !refrac && vi >= threshold;
      spike_d = upd && fire;
      rc_d    = !upd ? rc_q : refrac ? rc_q - RC_W'(1) : fire ? RC_W'(REFRAC_TICKS) : rc_q;
      v_d     = (!upd || refrac) ? v_q : !fire ? vi : (reset_mode == RST_ZERO || threshold == '0) ? '0 : vi - threshold;
   end
   // channel state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_q     <= '0;
         rc_q    <= '0;
         spike_q <= 1'b0;
      end else begin
         v_q     <= v_d;
         rc_q    <= rc_d;
         spike_q <= spike_d;
      end
   end
   assign spike = spike_q;
   assign vmem  = v_q;
endmodule

// File: rtl/lif_neuron_array.sv
// lif_neuron_array: N_CH LIF neurons sharing a time-step prescaler, with spike counters and a channel readout
module lif_neuron_array
   import lif_pkg::*;
#(
   parameter int N_CH         = 4,
   parameter int W            = 8,
   parameter int IN_W         = 8,
   parameter int TICK_DIV     = 10_000_000,
   parameter int REFRAC_TICKS = 2,
   parameter int CNT_W        = 8
) (
   input  logic                                      clk,
   input  logic                                      rst_n,
   input  logic                                      en,
   input  logic [N_CH*IN_W-1:0]                      cur_in,
   input  logic [W-1:0]                              threshold,
   input  logic [LS_W-1:0]                           leak_shift,
   input  logic                                      reset_mode,
   input  logic                                      clr_cnt,
   input  logic [(N_CH > 1 ? $clog2(N_CH) : 1)-1:0] sel,
   output logic [N_CH-1:0]                           spike,
   output logic                                      tick,
   output logic [W-1:0]                              vmem_out,
   output logic [CNT_W-1:0]                          cnt_out
);
   localparam int PS_W = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
   logic [PS_W-1:0]  ps_q, ps_d;
   logic             tick_q, upd;
   logic [N_CH-1:0]  spk;
   logic [W-1:0]     vmem_ch [N_CH];
   logic [CNT_W-1:0] cnt_q [N_CH];
   logic [CNT_W-1:0] cnt_d [N_CH];
   // prescaler: the last count of a step with en high is the update edge
   always_comb begin
      upd  = en && ps_q == PS_W'(TICK_DIV - 1);
      ps_d = upd ? '0 : en ? ps_q + PS_W'(1) : ps_q;
   end
   // saturating spike counters; a clear overrides a simultaneous spike
   always_comb begin
      for (int k = 0; k < N_CH; k++)
         cnt_d[k] = clr_cnt ? '0 : (spk[k] && cnt_q[k] != '1) ? cnt_q[k] + CNT_W'(1) : cnt_q[k];
   end
   // prescaler, tick strobe and counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ps_q   <= '0;
         tick_q <= 1'b0;
         for (int k = 0; k < N_CH; k++) cnt_q[k] <= '0;
      end else begin
         ps_q   <= ps_d;
         tick_q <= upd;
         for (int k = 0; k < N_CH; k++) cnt_q[k] <= cnt_d[k];
      end
   end
   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      lif_neuron #(.W(W), .IN_W(IN_W), .REFRAC_TICKS(REFRAC_TICKS)) u_neuron (
         .clk        (clk),
         .rst_n      (rst_n),
         .upd        (upd),
         .cur        (cur_in[i*IN_W +: IN_W]),
         .threshold  (threshold),
         .leak_shift (leak_shift),
         .reset_mode (reset_mode),
         .spike      (spk[i]),
         .vmem       (vmem_ch[i])
      );
   end
   assign spike    = spk;
   assign tick     = tick_q;
   assign vmem_out = vmem_ch[sel];
   assign cnt_out  = cnt_q[sel];
endmodule

// File: tb/tb_lif_neuron_array.sv
// tb_lif_neuron_array: directed scoreboard bench for the LIF neuron array
module tb_lif_neuron_array;
   import lif_pkg::*;
   localparam int N = 4, W = 8, IN_W = 8, TD = 4, RT = 2, CW = 8;
   logic              clk = 1'b0, rst_n = 1'b0, en = 1'b1, reset_mode = 1'b0, clr_cnt = 1'b0;
   logic [N*IN_W-1:0] cur_in = '0;
   logic [W-1:0]      threshold = 8'd255;
   logic [3:0]        leak_shift = 4'd8;
   logic [1:0]        sel = 2'd0;
   logic [N-1:0]      spike;
   logic              tick;
   logic [W-1:0]      vmem_out;
   logic [CW-1:0]     cnt_out;
   int vecs = 0, miss = 0, ncyc = 0, last_tick = 0;
   int mv[N], mrc[N], mcnt[N];
   typedef struct packed {
      logic [N-1:0]        spk;
      logic [N-1:0][W-1:0] vm;
   } exp_t;
   exp_t sb[$];

   lif_neuron_array #(.N_CH(N), .W(W), .IN_W(IN_W), .TICK_DIV(TD), .REFRAC_TICKS(RT), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .cur_in(cur_in), .threshold(threshold),
      .leak_shift(leak_shift), .reset_mode(reset_mode), .clr_cnt(clr_cnt), .sel(sel),
      .spike(spike), .tick(tick), .vmem_out(vmem_out), .cnt_out(cnt_out)
   );

   always #5 clk = ~clk;
   always @(posedge clk) ncyc <= ncyc + 1;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         miss++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic set_cur(input int k, input int v);
      cur_in[k*IN_W +: IN_W] = IN_W'(v);
   endtask

   task automatic model_reset();
      for (int k = 0; k < N; k++) begin
         mv[k] = 0; mrc[k] = 0; mcnt[k] = 0;
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_spike"}, spike, 0);
      chk({tag, "_tick"}, tick, 0);
      for (int k = 0; k < N; k++) begin
         sel = 2'(k);
         #1;
         chk($sformatf("%s_vmem%0d", tag, k), vmem_out, 0);
         chk($sformatf("%s_cnt%0d", tag, k), cnt_out, 0);
      end
   endtask

   task automatic chk_cnt();
      @(negedge clk);
      clr_cnt = 1'b0;
      for (int k = 0; k < N; k++) begin
         sel = 2'(k);
         #1;
         chk($sformatf("cnt%0d", k), cnt_out, mcnt[k]);
      end
   endtask

   // predict one time step, push it, wait for the DUT's tick and compare against the popped entry
   task automatic step(input int gap, input bit do_clr);
      exp_t e, got;
      int vi;
      int n;
      for (int k = 0; k < N; k++) begin
         e.spk[k] = 1'b0;
         if (mrc[k] > 0) mrc[k]--;
         else begin
            vi = mv[k] - (mv[k] >> leak_shift) + int'(cur_in[k*IN_W +: IN_W]);
            if (vi > 255) vi = 255;
            if (vi >= int'(threshold)) begin
               e.spk[k] = 1'b1;
               mrc[k] = RT;
               mv[k] = (reset_mode == RST_SUB && threshold != 0) ? vi - int'(threshold) : 0;
            end else mv[k] = vi;
         end
         e.vm[k] = W'(mv[k]);
      end
      sb.push_back(e);
      for (n = 1; n <= 40; n++) begin
         @(negedge clk);
         if (tick === 1'b1) break;
         chk("idle_spike", spike, 0);
      end
      chk("tick_seen", tick, 1);
      chk("tick_gap", ncyc - last_tick, gap);
      last_tick = ncyc;
      got = sb.pop_front();
      chk("spike", spike, got.spk);
      for (int k = 0; k < N; k++) begin
         sel = 2'(k);
         #1;
         chk($sformatf("vmem%0d", k), vmem_out, got.vm[k]);
      end
      if (do_clr) clr_cnt = 1'b1;
      for (int k = 0; k < N; k++)
         mcnt[k] = do_clr ? 0 : (got.spk[k] && mcnt[k] < 255) ? mcnt[k] + 1 : mcnt[k];
   endtask

   initial begin
      model_reset();
      repeat (2) @(negedge clk);
      chk_zero("rst");
      rst_n = 1'b1;
      last_tick = ncyc;
      // integrate with reset-to-zero and refractory
      threshold = 8'd50; leak_shift = 4'd8; reset_mode = RST_ZERO;
      set_cur(0, 10);
      repeat (8) step(TD, 1'b0);
      chk_cnt();
      // asynchronous reset mid-step with a nonzero membrane
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      model_reset();
      chk_zero("midrst");
      repeat (3) @(negedge clk);
      chk_zero("rsthold");
      rst_n = 1'b1;
      last_tick = ncyc;
      // leak decay
      threshold = 8'd255; leak_shift = 4'd1;
      set_cur(0, 100);
      step(TD, 1'b0);
      set_cur(0, 0);
      repeat (8) step(TD, 1'b0);
      // subtractive reset
      threshold = 8'd30; leak_shift = 4'd8; reset_mode = RST_SUB;
      set_cur(1, 20);
      repeat (5) step(TD, 1'b0);
      set_cur(1, 0);
      chk_cnt();
      // saturation at full scale
      threshold = 8'd255; reset_mode = RST_ZERO;
      set_cur(2, 200);
      repeat (2) step(TD, 1'b0);
      set_cur(2, 0);
      // zero threshold in subtractive mode still resets to zero
      threshold = 8'd0; reset_mode = RST_SUB;
      repeat (4) step(TD, 1'b0);
      chk_cnt();
      // enable low mid-step holds everything
      threshold = 8'd255; reset_mode = RST_ZERO;
      set_cur(3, 5);
      step(TD, 1'b0);
      repeat (2) @(negedge clk);
      en = 1'b0;
      repeat (10) begin
         @(negedge clk);
         chk("en_tick", tick, 0);
         sel = 2'd3;
         #1;
         chk("en_hold", vmem_out, W'(mv[3]));
      end
      en = 1'b1;
      step(TD + 10, 1'b0);
      // drain refractory, then clear counters in the spike cycle
      set_cur(3, 0);
      repeat (2) step(TD, 1'b0);
      threshold = 8'd0;
      step(TD, 1'b1);
      chk_cnt();
      // 300 spikes per channel saturate the counters
      repeat (900) step(TD, 1'b0);
      chk_cnt();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
      $finish;
   end
endmodule
